// File: rtl/carga_produto_escalar_pkg.sv
// rtl/carga_produto_escalar_pkg.sv - shared constants and state type for the dot-product loader
package produto_escalar_pkg;
    localparam int N_ELEM = 8;
    localparam int DATA_W = 32;
    localparam int RES_W  = 64;

    typedef enum logic [1:0] {FILL, START, WAIT, OUT} carga_state_t;
endpackage

// File: rtl/carga_produto_escalar_if.sv
// rtl/carga_produto_escalar_if.sv - operand stream, engine and result port bundle for the loader
interface carga_produto_escalar_if;
    import produto_escalar_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic                     clear;
    logic [3:0]               fill_level;

    logic                     pe_start;
    logic signed [DATA_W-1:0] pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7;
    logic signed [DATA_W-1:0] pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7;
    logic                     pe_done;
    logic signed [RES_W-1:0]  pe_result;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [RES_W-1:0]  out_data;
    logic                     out_err;

    // slave is the loader's own view; master is the source/engine/consumer side
    modport slave (
        input  in_valid, in_a, in_b, clear, pe_done, pe_result, out_ready,
        output in_ready, fill_level, pe_start,
        output pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7,
        output pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7,
        output out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_a, in_b, clear, pe_done, pe_result, out_ready,
        input  in_ready, fill_level, pe_start,
        input  pe_a0, pe_a1, pe_a2, pe_a3, pe_a4, pe_a5, pe_a6, pe_a7,
        input  pe_b0, pe_b1, pe_b2, pe_b3, pe_b4, pe_b5, pe_b6, pe_b7,
        input  out_valid, out_data, out_err
    );
endinterface

// File: rtl/carga_produto_escalar.sv
// rtl/carga_produto_escalar.sv - fills two 8-element vectors, launches the engine, returns its result
module carga_produto_escalar
    import produto_escalar_pkg::*;
#(
    parameter int N_ELEM  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    carga_produto_escalar_if.slave  bus
);
    localparam int IDX_W = $clog2(N_ELEM);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    carga_state_t                              state_q, state_d;
    logic [3:0]                                fill_q, fill_d;
    logic signed [0:N_ELEM-1][DATA_W-1:0]      a_q, a_d;
    logic signed [0:N_ELEM-1][DATA_W-1:0]      b_q, b_d;
    logic [CNT_W-1:0]                          cnt_q, cnt_d;
    logic signed [RES_W-1:0]                   out_data_q, out_data_d;
    logic                                      out_err_q, out_err_d;
    logic [IDX_W-1:0]                          idx;

    assign idx = fill_q[IDX_W-1:0];

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            FILL: begin
                // clear takes priority over a simultaneous transfer, which is dropped
                if (bus.clear) begin
                    fill_d = '0;
                end else if (bus.in_valid) begin
                    a_d[idx] = bus.in_a;
                    b_d[idx] = bus.in_b;
                    fill_d   = fill_q + 4'd1;
                    if (fill_q == 4'(N_ELEM - 1)) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a done pulse on the timeout cycle still delivers the real result
                if (bus.pe_done) begin
                    out_data_d = bus.pe_result;
                    out_err_d  = 1'b0;
                    state_d    = OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            fill_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign bus.in_ready   = (state_q == FILL) && !rst;
    assign bus.fill_level = fill_q;
    assign bus.pe_start   = (state_q == START);
    assign bus.out_valid  = (state_q == OUT);
    assign bus.out_data   = out_data_q;
    assign bus.out_err    = out_err_q;

    assign bus.pe_a0 = a_q[0];
    assign bus.pe_a1 = a_q[1];
    assign bus.pe_a2 = a_q[2];
    assign bus.pe_a3 = a_q[3];
    assign bus.pe_a4 = a_q[4];
    assign bus.pe_a5 = a_q[5];
    assign bus.pe_a6 = a_q[6];
    assign bus.pe_a7 = a_q[7];
    assign bus.pe_b0 = b_q[0];
    assign bus.pe_b1 = b_q[1];
    assign bus.pe_b2 = b_q[2];
    assign bus.pe_b3 = b_q[3];
    assign bus.pe_b4 = b_q[4];
    assign bus.pe_b5 = b_q[5];
    assign bus.pe_b6 = b_q[6];
    assign bus.pe_b7 = b_q[7];
endmodule

// File: tb/tb_carga_produto_escalar.sv
// tb/tb_carga_produto_escalar.sv - directed bench for the loader with a behavioural engine model
module tb_carga_produto_escalar;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    carga_produto_escalar_if bus ();

    carga_produto_escalar #(.N_ELEM(8), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: latches operands on start, pulses done 9 cycles later
    logic              eng_busy;
    logic [3:0]        eng_cnt;
    logic signed [63:0] eng_acc;
    logic              eng_done;
    logic              eng_enable;
    logic              stray_done;

    function automatic longint dot_now();
        longint s;
        s = 0;
        s += longint'(bus.pe_a0) * longint'(bus.pe_b0);
        s += longint'(bus.pe_a1) * longint'(bus.pe_b1);
        s += longint'(bus.pe_a2) * longint'(bus.pe_b2);
        s += longint'(bus.pe_a3) * longint'(bus.pe_b3);
        s += longint'(bus.pe_a4) * longint'(bus.pe_b4);
        s += longint'(bus.pe_a5) * longint'(bus.pe_b5);
        s += longint'(bus.pe_a6) * longint'(bus.pe_b6);
        s += longint'(bus.pe_a7) * longint'(bus.pe_b7);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_cnt  <= '0;
            eng_done <= 1'b0;
            eng_acc  <= '0;
        end else begin
            eng_done <= 1'b0;
            if (bus.pe_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 4'd1;
                eng_acc  <= dot_now();
            end else if (eng_busy) begin
                if (eng_cnt == 4'd8) begin
                    eng_busy <= 1'b0;
                    eng_done <= eng_enable;
                end
                eng_cnt <= eng_cnt + 4'd1;
            end
        end
    end

    assign bus.pe_done   = eng_done | stray_done;
    assign bus.pe_result = eng_acc;

    task automatic load_vec(input int a0, input int as, input int b0, input int bs);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = a0 + i * as;
            bus.in_b     = b0 + i * bs;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after load_vec; returns cycles from the pe_start sample to out_valid
    task automatic wait_result(output longint data, output bit err, output int lat,
                               output int starts, output bit rdy_bad);
        bit ok;
        ok = 0; starts = 0; rdy_bad = 0; lat = -1; data = 0; err = 0;
        for (int c = 0; c < 200; c++) begin
            if (bus.pe_start) starts++;
            if (bus.in_ready) rdy_bad = 1;
            if (bus.out_valid) begin
                ok   = 1;
                lat  = c;
                data = bus.out_data;
                err  = bus.out_err;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_result: out_valid got 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fill_level !== 4'd0) begin
            errors++;
            $display("FAIL accept: in_ready=%0b fill=%0d expected 1 and 0", bus.in_ready, bus.fill_level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fill_level !== 4'd0 || bus.pe_start !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_data !== 64'sd0 || bus.out_err !== 1'b0 ||
            bus.pe_a0 !== 32'sd0 || bus.pe_b7 !== 32'sd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%0b fill=%0d start=%0b ov=%0b od=%0d oe=%0b a0=%0d b7=%0d expected 1 0 0 0 0 0 0 0",
                     bus.in_ready, bus.fill_level, bus.pe_start, bus.out_valid, bus.out_data,
                     bus.out_err, bus.pe_a0, bus.pe_b7);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        longint d; bit e; int lat; int st; bit rb;
        load_vec(1, 1, 1, 1);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== 64'sd204 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d err %0b expected 204 err 0", d, e);
        end
        checks++;
        if (st !== 1) begin
            errors++;
            $display("FAIL basic_start_pulses: got %0d expected 1", st);
        end
        checks++;
        if (rb !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready: got 1 expected 0 from START to OUT");
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 10", lat);
        end
        accept();
    endtask

    task automatic test_sign();
        longint d; bit e; int lat; int st; bit rb;
        load_vec(-1, 0, 2147483647, 0);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== -64'sd17179869176 || e !== 1'b0) begin
            errors++;
            $display("FAIL sign_result: got %0d err %0b expected -17179869176 err 0", d, e);
        end
        accept();
    endtask

    task automatic test_clear();
        longint d; bit e; int lat; int st; bit rb;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 9; bus.in_b = 9;
            @(negedge clk);
        end
        checks++;
        if (bus.fill_level !== 4'd5) begin
            errors++;
            $display("FAIL clear_pre_fill: got %0d expected 5", bus.fill_level);
        end
        bus.clear = 1'b1; bus.in_a = 100; bus.in_b = 100;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_in_ready: got %0b expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.fill_level !== 4'd0) begin
            errors++;
            $display("FAIL clear_fill: got %0d expected 0", bus.fill_level);
        end
        load_vec(2, 0, 2, 0);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== 64'sd32 || e !== 1'b0) begin
            errors++;
            $display("FAIL clear_result: got %0d err %0b expected 32 err 0", d, e);
        end
        accept();
    endtask

    task automatic test_timeout();
        longint d; bit e; int lat; int st; bit rb;
        eng_enable = 1'b0;
        load_vec(1, 1, 1, 1);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== 64'sd0 || e !== 1'b1 || lat !== 65) begin
            errors++;
            $display("FAIL timeout_result: got data %0d err %0b lat %0d expected 0 1 65", d, e, lat);
        end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'sd0 || bus.out_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stray_done: ov=%0b od=%0d oe=%0b expected 1 0 1",
                     bus.out_valid, bus.out_data, bus.out_err);
        end
        eng_enable = 1'b1;
        accept();
    endtask

    task automatic test_backpressure();
        longint d; bit e; int lat; int st; bit rb; bit bad;
        load_vec(3, 0, -5, 0);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== -64'sd120) begin
            errors++;
            $display("FAIL bp_result: got %0d expected -120", d);
        end
        bad = 0;
        bus.in_valid = 1'b1; bus.in_a = 7; bus.in_b = 7;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== -64'sd120 || bus.in_ready !== 1'b0 ||
                bus.fill_level !== 4'd8) bad = 1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: got unstable OUT state expected data -120, in_ready 0, fill 8 for 20 cycles");
        end
        accept();
    endtask

    task automatic test_reset_mid_wait();
        longint d; bit e; int lat; int st; bit rb;
        load_vec(1, 0, 1, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fill_level !== 4'd0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 64'sd0 || bus.pe_a3 !== 32'sd0 || bus.pe_b3 !== 32'sd0) begin
            errors++;
            $display("FAIL midwait_reset: rdy=%0b fill=%0d ov=%0b od=%0d a3=%0d b3=%0d expected 1 0 0 0 0 0",
                     bus.in_ready, bus.fill_level, bus.out_valid, bus.out_data, bus.pe_a3, bus.pe_b3);
        end
        @(negedge clk);
        load_vec(1, 1, 8, -1);
        wait_result(d, e, lat, st, rb);
        checks++;
        if (d !== 64'sd120 || e !== 1'b0) begin
            errors++;
            $display("FAIL midwait_rerun: got %0d err %0b expected 120 err 0", d, e);
        end
        accept();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        eng_enable = 1'b1; stray_done = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.clear = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_sign();
        test_clear();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
